// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Receiving end of a VGA timing stream. Samples hs/vs/blank, measures line and frame
// lengths plus the hsync width, rebuilds active-pixel coordinates, and declares lock
// once enough consecutive frames match the expected timing.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank,
  output logic [9:0]  RxX,
  output logic [9:0]  RxY,
  output logic        RxValid,
  output logic        LineStart,
  output logic        FrameStart,
  output logic        Locked,
  output logic [10:0] HTotal,
  output logic [9:0]  VTotal,
  output logic [7:0]  LockLoss
);

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [9:0]  V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // Input sampling stage
  logic hs_q, hs_qq;
  logic vs_q, vs_qq;
  logic blank_q;

  logic hs_fall;
  logic hs_rise;
  logic vs_fall;

  // Horizontal measurement
  logic [10:0] hcnt;
  logic [10:0] hcnt_inc;
  logic [10:0] hsw;
  logic [10:0] hsw_last;
  logic        line_ok;

  // Vertical measurement
  logic [9:0]  vcnt;
  logic [9:0]  vtotal_meas;
  logic        frame_bad;
  logic        frame_ok;

  // Coordinate reconstruction
  logic [9:0]  px_cnt;
  logic        line_active;

  // Lock FSM
  state_t      state;
  state_t      state_nxt;
  logic [3:0]  good_cnt;
  logic [3:0]  good_nxt;
  logic [7:0]  loss_nxt;

  // Register the sync pins twice so edges are detected on clean, aligned samples.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_q    <= 1'b0;
      hs_qq   <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= hs;
      hs_qq   <= hs_q;
      vs_q    <= vs;
      vs_qq   <= vs_q;
      blank_q <= blank;
    end
  end

  assign hs_fall = hs_qq & ~hs_q;
  assign hs_rise = ~hs_qq & hs_q;
  assign vs_fall = vs_qq & ~vs_q;

  assign hcnt_inc = sat_inc11(hcnt);

  // A line is judged when it ends: its length is hcnt+1 and its sync pulse was
  // captured into hsw_last when hs returned high earlier in the same line.
  assign line_ok = (hcnt_inc == H_TOTAL_C) && (hsw_last == H_SYNC_C);

  // Measure line length and hsync width; the fall cycle itself is the first low clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hcnt     <= '0;
      HTotal   <= '0;
      hsw      <= '0;
      hsw_last <= '0;
    end else begin
      if (hs_fall) begin
        hcnt   <= '0;
        HTotal <= hcnt_inc;
      end else begin
        hcnt   <= hcnt_inc;
      end

      if (hs_fall) begin
        hsw <= 11'd1;
      end else if (!hs_q) begin
        hsw <= sat_inc11(hsw);
      end

      if (hs_rise) begin
        hsw_last <= hsw;
      end
    end
  end

  // A line edge landing on the same cycle as the frame edge still belongs to the
  // frame that is closing, so it is folded into both the count and the verdict.
  assign vtotal_meas = hs_fall ? sat_inc10(vcnt) : vcnt;
  assign frame_ok    = !frame_bad && (!hs_fall || line_ok) && (vtotal_meas == V_TOTAL_C);

  // Count lines per frame and remember whether any line in the frame failed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vcnt      <= '0;
      VTotal    <= '0;
      frame_bad <= 1'b0;
    end else if (vs_fall) begin
      vcnt      <= '0;
      VTotal    <= vtotal_meas;
      frame_bad <= 1'b0;
    end else begin
      if (hs_fall) begin
        vcnt <= sat_inc10(vcnt);
      end
      if (hs_fall && !line_ok) begin
        frame_bad <= 1'b1;
      end
    end
  end

  // Rebuild the pixel index: RxX shows the 0-based index of the pixel now on blank_q,
  // px_cnt holds how many visible pixels this line has produced so far.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RxX    <= '0;
      px_cnt <= '0;
    end else if (hs_fall) begin
      RxX    <= '0;
      px_cnt <= {9'd0, blank_q};
    end else if (blank_q) begin
      RxX    <= px_cnt;
      px_cnt <= sat_inc10(px_cnt);
    end
  end

  // Rebuild the line index: only lines that carried visible pixels advance RxY.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      line_active <= 1'b0;
      RxY         <= '0;
    end else begin
      if (hs_fall) begin
        line_active <= blank_q;
      end else if (blank_q) begin
        line_active <= 1'b1;
      end

      if (vs_fall) begin
        RxY <= '0;
      end else if (hs_fall && line_active) begin
        RxY <= sat_inc10(RxY);
      end
    end
  end

  // Output pulses and pixel-valid, aligned with the coordinate registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
      RxValid    <= 1'b0;
    end else begin
      LineStart  <= hs_fall;
      FrameStart <= vs_fall;
      RxValid    <= blank_q & Locked;
    end
  end

  // Lock FSM state, good-frame counter and lock-loss counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      LockLoss <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      LockLoss <= loss_nxt;
    end
  end

  // Lock decisions happen only at frame edges; the first frame after SEARCH is partial
  // and therefore never scored.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    loss_nxt  = LockLoss;
    unique case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (vs_fall) begin
          if (frame_ok) begin
            good_nxt = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == LOCK_N) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (vs_fall && !frame_ok) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
          loss_nxt  = sat_inc8(LockLoss);
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = '0;
      end
    endcase
  end

  assign Locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
// Directed bench for vga_sync_receiver using a reduced raster (64 clocks x 16 lines)
// so that many whole frames fit in a short run. Raster: hs low for h<8, visible pixels
// h=12..59 on lines 0..11 (48x12), vs low on lines 13..14 switching at h=0.
module tb_vga_sync_receiver;

  localparam int HT  = 64;
  localparam int HS  = 8;
  localparam int VT  = 16;
  localparam int HA0 = 12;
  localparam int HAW = 48;
  localparam int VAL = 12;
  localparam int VS0 = 13;
  localparam int VSL = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        blank = 1'b0;
  logic [9:0]  RxX;
  logic [9:0]  RxY;
  logic        RxValid;
  logic        LineStart;
  logic        FrameStart;
  logic        Locked;
  logic [10:0] HTotal;
  logic [9:0]  VTotal;
  logic [7:0]  LockLoss;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  vga_sync_receiver #(
    .H_TOTAL    (HT),
    .H_SYNC     (HS),
    .V_TOTAL    (VT),
    .LOCK_FRAMES(2)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .hs        (hs),
    .vs        (vs),
    .blank     (blank),
    .RxX       (RxX),
    .RxY       (RxY),
    .RxValid   (RxValid),
    .LineStart (LineStart),
    .FrameStart(FrameStart),
    .Locked    (Locked),
    .HTotal    (HTotal),
    .VTotal    (VTotal),
    .LockLoss  (LockLoss)
  );

  function automatic logic vs_level(input int v);
    return (v >= VS0 && v < VS0 + VSL) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic blank_level(input int v, input int h);
    return (v < VAL && h >= HA0 && h < HA0 + HAW) ? 1'b1 : 1'b0;
  endfunction

  // Pins change on the falling edge; outputs are also read on falling edges.
  task automatic drive_pins(input logic h_l, input logic v_l, input logic b_l);
    @(negedge Clk);
    hs    = h_l;
    vs    = v_l;
    blank = b_l;
  endtask

  // Drive lines v0..v1-1; line odd_v may get a different length and hsync width.
  task automatic run_lines(input int v0, input int v1, input int odd_v,
                           input int odd_len, input int odd_hsw);
    int len;
    int hw;
    for (int v = v0; v < v1; v++) begin
      len = (v == odd_v) ? odd_len : HT;
      hw  = (v == odd_v) ? odd_hsw : HS;
      for (int h = 0; h < len; h++) begin
        drive_pins((h >= hw) ? 1'b1 : 1'b0, vs_level(v), blank_level(v, h));
      end
    end
  endtask

  task automatic run_frame();
    run_lines(0, VT, -1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    hs = 1'b1; vs = 1'b1; blank = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    hs = 1'b1; vs = 1'b1; blank = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_checks++; if (Locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", Locked); else n_pass++;
    n_checks++; if (RxValid !== 1'b0) $display("FAIL reset_rxvalid: got %0b want 0", RxValid); else n_pass++;
    n_checks++; if (RxX !== 10'd0) $display("FAIL reset_rxx: got %0d want 0", RxX); else n_pass++;
    n_checks++; if (RxY !== 10'd0) $display("FAIL reset_rxy: got %0d want 0", RxY); else n_pass++;
    n_checks++; if (HTotal !== 11'd0) $display("FAIL reset_htotal: got %0d want 0", HTotal); else n_pass++;
    n_checks++; if (VTotal !== 10'd0) $display("FAIL reset_vtotal: got %0d want 0", VTotal); else n_pass++;
    n_checks++; if (LockLoss !== 8'd0) $display("FAIL reset_lockloss: got %0d want 0", LockLoss); else n_pass++;
    n_checks++; if (LineStart !== 1'b0) $display("FAIL reset_linestart: got %0b want 0", LineStart); else n_pass++;
    n_checks++; if (FrameStart !== 1'b0) $display("FAIL reset_framestart: got %0b want 0", FrameStart); else n_pass++;
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    n_checks++; if (LineStart !== 1'b0) $display("FAIL idle_linestart: got %0b want 0", LineStart); else n_pass++;
  endtask

  task automatic test_nominal_lock();
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL nominal_lock_f1: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL nominal_lock_f2: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL nominal_lock_f3: got %0b want 1", Locked); else n_pass++;
    n_checks++; if (HTotal !== 11'd64) $display("FAIL nominal_htotal: got %0d want 64", HTotal); else n_pass++;
    n_checks++; if (VTotal !== 10'd16) $display("FAIL nominal_vtotal: got %0d want 16", VTotal); else n_pass++;
    n_checks++; if (LockLoss !== 8'd0) $display("FAIL nominal_lockloss: got %0d want 0", LockLoss); else n_pass++;
  endtask

  // Coordinates and pulses appear two clocks after the pins that cause them.
  task automatic test_pixel_coords();
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        drive_pins((h >= HS) ? 1'b1 : 1'b0, vs_level(v), blank_level(v, h));
        if (v == 0 && h == HA0 + 2) begin
          n_checks++; if (RxX !== 10'd0) $display("FAIL first_px_x: got %0d want 0", RxX); else n_pass++;
          n_checks++; if (RxY !== 10'd0) $display("FAIL first_px_y: got %0d want 0", RxY); else n_pass++;
          n_checks++; if (RxValid !== 1'b1) $display("FAIL first_px_valid: got %0b want 1", RxValid); else n_pass++;
        end
        if (v == VAL - 1 && h == HA0 + HAW + 1) begin
          n_checks++; if (RxX !== 10'd47) $display("FAIL last_px_x: got %0d want 47", RxX); else n_pass++;
          n_checks++; if (RxY !== 10'd11) $display("FAIL last_px_y: got %0d want 11", RxY); else n_pass++;
          n_checks++; if (RxValid !== 1'b1) $display("FAIL last_px_valid: got %0b want 1", RxValid); else n_pass++;
        end
        if (v == VAL - 1 && h == HA0 + HAW + 2) begin
          n_checks++; if (RxValid !== 1'b0) $display("FAIL blank_valid: got %0b want 0", RxValid); else n_pass++;
          n_checks++; if (RxX !== 10'd47) $display("FAIL blank_x_hold: got %0d want 47", RxX); else n_pass++;
        end
        if (v == 5 && h == 2) begin
          n_checks++; if (LineStart !== 1'b1) $display("FAIL line_pulse: got %0b want 1", LineStart); else n_pass++;
          n_checks++; if (FrameStart !== 1'b0) $display("FAIL no_frame_pulse: got %0b want 0", FrameStart); else n_pass++;
        end
        if (v == 5 && h == 3) begin
          n_checks++; if (LineStart !== 1'b0) $display("FAIL line_pulse_end: got %0b want 0", LineStart); else n_pass++;
        end
        if (v == VS0 && h == 2) begin
          n_checks++; if (FrameStart !== 1'b1) $display("FAIL frame_pulse: got %0b want 1", FrameStart); else n_pass++;
          n_checks++; if (LineStart !== 1'b1) $display("FAIL frame_line_pulse: got %0b want 1", LineStart); else n_pass++;
        end
        if (v == VS0 && h == 3) begin
          n_checks++; if (FrameStart !== 1'b0) $display("FAIL frame_pulse_end: got %0b want 0", FrameStart); else n_pass++;
        end
      end
    end
    n_checks++; if (Locked !== 1'b1) $display("FAIL pixel_frame_locked: got %0b want 1", Locked); else n_pass++;
  endtask

  task automatic test_long_line();
    run_lines(0, 7, 5, HT + 1, HS);
    n_checks++; if (HTotal !== 11'd65) $display("FAIL long_htotal: got %0d want 65", HTotal); else n_pass++;
    run_lines(7, VS0, -1, 0, 0);
    n_checks++; if (Locked !== 1'b1) $display("FAIL long_hold_lock: got %0b want 1", Locked); else n_pass++;
    run_lines(VS0, VT, -1, 0, 0);
    n_checks++; if (Locked !== 1'b0) $display("FAIL long_drop_lock: got %0b want 0", Locked); else n_pass++;
    n_checks++; if (LockLoss !== 8'd1) $display("FAIL long_lockloss: got %0d want 1", LockLoss); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL long_relock_f1: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL long_relock_f2: got %0b want 1", Locked); else n_pass++;
    n_checks++; if (LockLoss !== 8'd1) $display("FAIL long_lockloss_keep: got %0d want 1", LockLoss); else n_pass++;
  endtask

  // Sync stops for longer than the line counter range: HTotal saturates, lock holds
  // until the frame edge rejects the frame.
  task automatic test_no_activity();
    run_lines(0, 5, -1, 0, 0);
    repeat (2100) drive_pins(1'b1, 1'b1, 1'b0);
    n_checks++; if (Locked !== 1'b1) $display("FAIL idle_lock_hold: got %0b want 1", Locked); else n_pass++;
    run_lines(5, 6, -1, 0, 0);
    n_checks++; if (HTotal !== 11'd2047) $display("FAIL idle_htotal_sat: got %0d want 2047", HTotal); else n_pass++;
    run_lines(6, VT, -1, 0, 0);
    n_checks++; if (Locked !== 1'b0) $display("FAIL idle_drop_lock: got %0b want 0", Locked); else n_pass++;
    n_checks++; if (LockLoss !== 8'd2) $display("FAIL idle_lockloss: got %0d want 2", LockLoss); else n_pass++;
    run_frame();
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL idle_relock: got %0b want 1", Locked); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    run_lines(0, 6, -1, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++; if (Locked !== 1'b0) $display("FAIL midrst_locked: got %0b want 0", Locked); else n_pass++;
    n_checks++; if (LockLoss !== 8'd0) $display("FAIL midrst_lockloss: got %0d want 0", LockLoss); else n_pass++;
    n_checks++; if (HTotal !== 11'd0) $display("FAIL midrst_htotal: got %0d want 0", HTotal); else n_pass++;
    n_checks++; if (VTotal !== 10'd0) $display("FAIL midrst_vtotal: got %0d want 0", VTotal); else n_pass++;
    n_checks++; if (RxY !== 10'd0) $display("FAIL midrst_rxy: got %0d want 0", RxY); else n_pass++;
    n_checks++; if (RxX !== 10'd0) $display("FAIL midrst_rxx: got %0d want 0", RxX); else n_pass++;
    hs = 1'b1; vs = 1'b1; blank = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL midrst_relock_f1: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL midrst_relock_f2: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL midrst_relock_f3: got %0b want 1", Locked); else n_pass++;
  endtask

  // A narrow hsync in ACQUIRE must restart the good-frame count from zero.
  task automatic test_short_hsync();
    do_reset();
    run_frame();
    run_frame();
    run_lines(0, VT, 5, HT, HS - 1);
    n_checks++; if (Locked !== 1'b0) $display("FAIL hsw_reject: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL hsw_restart: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL hsw_relock: got %0b want 1", Locked); else n_pass++;
  endtask

  // One frame one line short: measured and rejected, so lock needs two more good frames.
  task automatic test_short_frame();
    do_reset();
    run_frame();
    run_lines(0, VT - 1, -1, 0, 0);
    n_checks++; if (VTotal !== 10'd16) $display("FAIL sf_vtotal_pre: got %0d want 16", VTotal); else n_pass++;
    n_checks++; if (Locked !== 1'b0) $display("FAIL sf_lock_pre: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (VTotal !== 10'd15) $display("FAIL sf_vtotal_short: got %0d want 15", VTotal); else n_pass++;
    n_checks++; if (Locked !== 1'b0) $display("FAIL sf_reject: got %0b want 0", Locked); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b0) $display("FAIL sf_restart: got %0b want 0", Locked); else n_pass++;
    n_checks++; if (VTotal !== 10'd16) $display("FAIL sf_vtotal_post: got %0d want 16", VTotal); else n_pass++;
    run_frame();
    n_checks++; if (Locked !== 1'b1) $display("FAIL sf_relock: got %0b want 1", Locked); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal_lock();
    test_pixel_coords();
    test_long_line();
    test_no_activity();
    test_reset_midframe();
    test_short_hsync();
    test_short_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
